// File: rtl/lookahead_ram_pkg.sv
// Shared types and helpers for the lookahead multiport RAM: clear FSM states,
// a constant clog2, and the packed read-port slice helper.
package lookahead_ram_pkg;

  typedef enum logic {
    CLEARING = 1'b0,
    READY    = 1'b1
  } clr_state_e;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((r < 32) && ((64'd1 << r) < 64'(n))) r++;
    return r;
  endfunction

  // LSB position of port 'port' in a bus packing 'width' bits per port
  function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/lookahead_ram_read_port.sv
// One read port: private array copy, address range check, write bypass and
// registered read data. LOOKAHEAD_RAM_OUTPUT_REG_EN adds an output stage.
module lookahead_ram_read_port
  import lookahead_ram_pkg::*;
#(
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned ADDRESS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_en_i,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0]    wr_data_i,
  input  logic                     byp_en_i,
  input  logic [ADDRESS_WIDTH-1:0] rd_addr_i,
  output logic [DATA_WIDTH-1:0]    rd_data_o
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  rd_in_range_c;
  logic                  rd_hit_c;
  logic [DATA_WIDTH-1:0] rd_word_c;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Write address is always in range here: the top filters user writes
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[IDX_W'(wr_addr_i)] <= wr_data_i;
  end

  assign rd_in_range_c = (32'(rd_addr_i) < DEPTH);
  assign rd_hit_c      = byp_en_i && rd_in_range_c && (wr_addr_i == rd_addr_i);

  always_comb begin
    rd_word_c = '0;
    if (rd_hit_c)           rd_word_c = wr_data_i;
    else if (rd_in_range_c) rd_word_c = mem_q[IDX_W'(rd_addr_i)];
  end

`ifdef LOOKAHEAD_RAM_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0]    stg_data_q;
  logic [ADDRESS_WIDTH-1:0] stg_addr_q;
  logic                     stg_valid_q;
  logic                     stg_hit_c;

  // Second bypass window: a write landing one cycle after the address was sampled
  assign stg_hit_c = byp_en_i && stg_valid_q && (wr_addr_i == stg_addr_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stg_data_q  <= '0;
      stg_addr_q  <= '0;
      stg_valid_q <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      stg_data_q  <= rd_word_c;
      stg_addr_q  <= rd_addr_i;
      stg_valid_q <= rd_in_range_c;
      rd_data_q   <= stg_hit_c ? wr_data_i : stg_data_q;
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rd_data_q <= '0;
    else          rd_data_q <= rd_word_c;
  end
`endif

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/lookahead_multiport_ram.sv
// Lookahead multiport RAM top: clear FSM, clear counter and write/clear mux
// feeding NUM_READ_PORTS read ports. Optional macro: LOOKAHEAD_RAM_OUTPUT_REG_EN.
module lookahead_multiport_ram
  import lookahead_ram_pkg::*;
#(
  parameter int unsigned DEPTH          = 16,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDRESS_WIDTH  = 4,
  parameter int unsigned NUM_READ_PORTS = 2,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                                     clk,
  input  logic                                     reset_n,
  input  logic                                     clr,
  input  logic [ADDRESS_WIDTH-1:0]                 wr_address,
  input  logic [DATA_WIDTH-1:0]                    wr_writedata,
  input  logic                                     wr_write,
  output logic                                     wr_waitrequest,
  input  logic [NUM_READ_PORTS*ADDRESS_WIDTH-1:0]  rd_address,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]     rd_readdata
);

  localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
  localparam bit                       CLR_EN    = (CLEAR_ON_RESET != 0);

  clr_state_e               state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] cnt_q, cnt_d;
  logic                     wait_q, wait_d;

  logic                     clr_wr_c;
  logic                     user_wr_c;
  logic                     mem_we_c;
  logic [ADDRESS_WIDTH-1:0] mem_waddr_c;
  logic [DATA_WIDTH-1:0]    mem_wdata_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEARING;
      cnt_q   <= LAST_ADDR;
      wait_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wait_q  <= wait_d;
    end
  end

  // Clear sequence walks DEPTH-1 down to 0; clr restarts it from the top
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wait_d  = wait_q;
    case (state_q)
      CLEARING: begin
        if (!CLR_EN) begin
          state_d = READY;
          wait_d  = 1'b0;
        end else if (clr) begin
          cnt_d = LAST_ADDR;
        end else if (cnt_q == '0) begin
          state_d = READY;
          wait_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - ADDRESS_WIDTH'(1);
        end
      end
      READY: begin
        if (CLR_EN && clr) begin
          state_d = CLEARING;
          cnt_d   = LAST_ADDR;
          wait_d  = 1'b1;
        end
      end
    endcase
  end

  // Clear writes own the array while clearing; user writes only when idle and in range
  assign clr_wr_c    = CLR_EN && reset_n && (state_q == CLEARING);
  assign user_wr_c   = wr_write && !wait_q && (32'(wr_address) < DEPTH);
  assign mem_we_c    = clr_wr_c || user_wr_c;
  assign mem_waddr_c = clr_wr_c ? cnt_q : wr_address;
  assign mem_wdata_c = clr_wr_c ? '0 : wr_writedata;

  assign wr_waitrequest = wait_q;

  for (genvar p = 0; p < int'(NUM_READ_PORTS); p++) begin : g_port
    lookahead_ram_read_port #(
      .DEPTH         (DEPTH),
      .DATA_WIDTH    (DATA_WIDTH),
      .ADDRESS_WIDTH (ADDRESS_WIDTH)
    ) u_port (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_en_i   (mem_we_c),
      .wr_addr_i (mem_waddr_c),
      .wr_data_i (mem_wdata_c),
      .byp_en_i  (user_wr_c),
      .rd_addr_i (rd_address[port_lsb(p, ADDRESS_WIDTH) +: ADDRESS_WIDTH]),
      .rd_data_o (rd_readdata[port_lsb(p, DATA_WIDTH) +: DATA_WIDTH])
    );
  end

endmodule

// File: tb/tb_lookahead_multiport_ram.sv
// Bench for lookahead_multiport_ram (DEPTH=5, 2 read ports): vector table,
// hand-written clear/reset/bypass sequences and a random run against a model.
module tb_lookahead_multiport_ram;

  localparam int DEPTH = 5;
  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int NRP   = 2;
`ifdef LOOKAHEAD_RAM_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic                clk;
  logic                reset_n;
  logic                clr;
  logic [AW-1:0]       wr_address;
  logic [DW-1:0]       wr_writedata;
  logic                wr_write;
  logic                wr_waitrequest;
  logic [NRP*AW-1:0]   rd_address;
  logic [NRP*DW-1:0]   rd_readdata;

  lookahead_multiport_ram #(
    .DEPTH          (DEPTH),
    .DATA_WIDTH     (DW),
    .ADDRESS_WIDTH  (AW),
    .NUM_READ_PORTS (NRP),
    .CLEAR_ON_RESET (1)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .clr            (clr),
    .wr_address     (wr_address),
    .wr_writedata   (wr_writedata),
    .wr_write       (wr_write),
    .wr_waitrequest (wr_waitrequest),
    .rd_address     (rd_address),
    .rd_readdata    (rd_readdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: memory image plus per-port expected read pipeline
  int m_mem   [DEPTH];
  bit m_known [DEPTH];
  bit m_wait;
  int m_next;
  int p_val [NRP];
  bit p_known [NRP];
  bit p_ok [NRP];
  int p_addr [NRP];
  int e_val [NRP];
  bit e_known [NRP];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int rd(input int p);
    return int'(rd_readdata[p*DW +: DW]);
  endfunction

  task automatic model_reset();
    m_wait = 1'b1;
    m_next = DEPTH - 1;
    for (int p = 0; p < NRP; p++) begin
      p_val[p] = 0; p_known[p] = 1'b1; p_ok[p] = 1'b0; p_addr[p] = 0;
      e_val[p] = 0; e_known[p] = 1'b1;
    end
  endtask

  task automatic model_edge();
    int  rv [NRP];
    bit  rk [NRP];
    bit  ok [NRP];
    int  ra [NRP];
    int  wa;
    int  wd;
    bit  acc;
    wa  = int'(wr_address);
    wd  = int'(wr_writedata);
    acc = wr_write && !m_wait && (wa < DEPTH);
    for (int p = 0; p < NRP; p++) begin
      ra[p] = int'(rd_address[p*AW +: AW]);
      ok[p] = ra[p] < DEPTH;
      rv[p] = ok[p] ? m_mem[ra[p]] : 0;
      rk[p] = ok[p] ? m_known[ra[p]] : 1'b1;
      if (acc && ok[p] && ra[p] == wa) begin rv[p] = wd; rk[p] = 1'b1; end
      if (LAT == 2) begin
        if (acc && p_ok[p] && p_addr[p] == wa) begin p_val[p] = wd; p_known[p] = 1'b1; end
        e_val[p] = p_val[p]; e_known[p] = p_known[p];
        p_val[p] = rv[p]; p_known[p] = rk[p]; p_ok[p] = ok[p]; p_addr[p] = ra[p];
      end else begin
        e_val[p] = rv[p]; e_known[p] = rk[p];
      end
    end
    if (m_wait) begin
      m_mem[m_next] = 0; m_known[m_next] = 1'b1;
      if (clr)              m_next = DEPTH - 1;
      else if (m_next == 0) m_wait = 1'b0;
      else                  m_next--;
    end else begin
      if (acc) begin m_mem[wa] = wd; m_known[wa] = 1'b1; end
      if (clr) begin m_wait = 1'b1; m_next = DEPTH - 1; end
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
    check("waitrequest", int'(wr_waitrequest), int'(m_wait));
    for (int p = 0; p < NRP; p++)
      if (e_known[p]) check($sformatf("model_rd_p%0d", p), rd(p), e_val[p]);
  endtask

  task automatic drive(input bit c, input bit we, input int wa, input int wd,
                       input int r0, input int r1);
    clr          = c;
    wr_write     = we;
    wr_address   = AW'(wa);
    wr_writedata = DW'(wd);
    rd_address   = {AW'(r1), AW'(r0)};
  endtask

  // Idle cycles until data for the last sampled address reaches the output
  task automatic settle();
    for (int i = 1; i < LAT; i++) begin
      clr = 1'b0; wr_write = 1'b0;
      step();
    end
  endtask

  task automatic count_clear(output int n);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      n++;
      if (!wr_waitrequest) break;
    end
  endtask

  typedef struct {
    bit we; int wa; int wd; int r0; int r1; int e0; int e1;
  } vec_t;

  vec_t vecs [7];
  int   n_edges;
  int   hi;

  initial begin
    vecs[0] = '{1'b1, 3, 'hA5, 3, 3, 'hA5, 'hA5};
    vecs[1] = '{1'b0, 0, 'h00, 3, 0, 'hA5, 'h00};
    vecs[2] = '{1'b1, 0, 'h5A, 0, 3, 'h5A, 'hA5};
    vecs[3] = '{1'b1, 7, 'h3C, 7, 3, 'h00, 'hA5};
    vecs[4] = '{1'b1, 4, 'h77, 4, 5, 'h77, 'h00};
    vecs[5] = '{1'b0, 1, 'h12, 1, 4, 'h00, 'h77};
    vecs[6] = '{1'b0, 0, 'h00, 1, 2, 'h00, 'h00};

    for (int a = 0; a < DEPTH; a++) m_known[a] = 1'b0;
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    step();
    check("reset_wait", int'(wr_waitrequest), 1);
    check("reset_rd0", rd(0), 0);
    check("reset_rd1", rd(1), 0);
    step();
    reset_n = 1'b1;

    count_clear(n_edges);
    check("init_clear_edges", n_edges, DEPTH);

    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 0, 0, 0, a, DEPTH - 1 - a);
      step();
      settle();
      check($sformatf("init_rd0_a%0d", a), rd(0), 0);
      check($sformatf("init_rd1_a%0d", a), rd(1), 0);
    end

    foreach (vecs[i]) begin
      drive(0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].r0, vecs[i].r1);
      step();
      settle();
      check($sformatf("vec%0d_rd0", i), rd(0), vecs[i].e0);
      check($sformatf("vec%0d_rd1", i), rd(1), vecs[i].e1);
      check($sformatf("vec%0d_wait", i), int'(wr_waitrequest), 0);
    end

    // Back-to-back writes to the address being read: the later one wins
    drive(0, 1, 2, 'h11, 2, 2);
    step();
`ifndef LOOKAHEAD_RAM_OUTPUT_REG_EN
    check("dw_first_rd0", rd(0), 'h11);
`endif
    drive(0, 1, 2, 'h22, 2, 2);
    step();
    check("dw_rd0", rd(0), 'h22);
    check("dw_rd1", rd(1), 'h22);

    // Fill with 0xFF, then clear; a write during the clear must not stick or bypass
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 1, a, 'hFF, a, a);
      step();
    end
    drive(1, 0, 0, 0, 0, 0);
    step();
    hi = wr_waitrequest ? 1 : 0;
    for (int i = 0; i < 20 && wr_waitrequest; i++) begin
      if (i == 0) drive(0, 1, 0, 'h3C, 0, 0);
      else        drive(0, 0, 0, 0, 0, 0);
      step();
      if (i == LAT - 1) check("clear_no_bypass", rd(0), 'hFF);
      if (wr_waitrequest) hi++;
    end
    check("clr_wait_cycles", hi, DEPTH);
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 0, 0, 0, a, DEPTH - 1 - a);
      step();
      settle();
      check($sformatf("clr_rd0_a%0d", a), rd(0), 0);
      check($sformatf("clr_rd1_a%0d", a), rd(1), 0);
    end

    // Reset arriving two cycles into a clear
    drive(0, 1, 1, 'h99, 1, 1);
    step();
    settle();
    check("pre_rst_rd0", rd(0), 'h99);
    drive(1, 0, 0, 0, 1, 1);
    step();
    drive(0, 0, 0, 0, 1, 1);
    step();
    step();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("async_rst_wait", int'(wr_waitrequest), 1);
    check("async_rst_rd0", rd(0), 0);
    check("async_rst_rd1", rd(1), 0);
    step();
    step();
    reset_n = 1'b1;
    count_clear(n_edges);
    check("rst_clear_edges", n_edges, DEPTH);

    for (int i = 0; i < 100 * DEPTH; i++) begin
      drive($urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lookahead_multiport_ram.md
# lookahead_multiport_ram

Parametrised lookahead multiport memory: one write port and NUM_READ_PORTS independent registered read ports over a DEPTH x DATA_WIDTH array. It provides:
- write-to-read bypass, so a read never returns stale data during the lookahead window;
- hardware clearing of every location after reset and on a synchronous clear request.

It is the generic state and context store behind DFA and packet-processing blocks in the SOPC datapath components.

## Interface
- DEPTH, 16, number of words; any value >= 1, not restricted to powers of two
- DATA_WIDTH, 8, bits per word
- ADDRESS_WIDTH, 4, address bits; must satisfy 2**ADDRESS_WIDTH >= DEPTH
- NUM_READ_PORTS, 2, number of read ports (>= 1)
- CLEAR_ON_RESET, 1, when 1, zero every location after reset and on clr
- clk  in  1  single clock; all state changes on its rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- clr  in  1  synchronous request to restart the clear sequence
- wr_address  in  ADDRESS_WIDTH  write address
- wr_writedata  in  DATA_WIDTH  write data
- wr_write  in  1  write strobe
- wr_waitrequest  out  1  high while clearing; writes are ignored while high
- rd_address  in  NUM_READ_PORTS*ADDRESS_WIDTH  read addresses; port p occupies bits [p*ADDRESS_WIDTH +: ADDRESS_WIDTH]
- rd_readdata  out  NUM_READ_PORTS*DATA_WIDTH  registered read data, packed the same way

## Operation
- Reset values: wr_waitrequest=1; all rd_readdata=0; clear counter=DEPTH-1; all bypass flags=0.
- Clear FSM has two states, CLEARING and READY.
  - CLEARING:
    - each cycle, write 0 to the address held in the counter;
    - decrement the counter while it is > 0;
    - when the counter is 0, go to READY and drop wr_waitrequest at that edge.
  - READY → CLEARING: on clr=1 with CLEAR_ON_RESET=1. Reload the counter to DEPTH-1 and raise wr_waitrequest.
  - clr=1 during CLEARING reloads the counter; the clear restarts from DEPTH-1.
- With CLEAR_ON_RESET=0: the FSM enters READY at the first edge after reset release, clr is ignored, and memory contents are undefined.
- Writes:
  - accepted only when wr_write=1 and wr_waitrequest=0;
  - a wr_address >= DEPTH is dropped;
  - a user write is never merged with a clear write.
- Reads:
  - each port samples its address independently; all ports may read the same address;
  - a port address >= DEPTH returns 0 and never bypasses.
- Bypass: if an accepted write in the same cycle hits a port's read address, that port returns the new write data, not the old memory word.
- Bypass is suppressed while wr_waitrequest=1. During CLEARING, read data comes from the array: cleared words return 0, uncleared words return their old contents.
- Reset asserted mid-clear or mid-write: all registers return to reset values immediately. The array is not written during reset, and the clear restarts after release.

## Timing
- Read latency is 1 cycle: address in cycle n, rd_readdata valid in cycle n+1. With the output register (see Configuration) it is 2 cycles.
- Bypass window is cycle n at 1-cycle latency, and cycles n and n+1 at 2-cycle latency.
- If writes to the read address occur in both n and n+1, the cycle n+1 data wins.
- After reset release, wr_waitrequest falls on the DEPTH-th rising edge (CLEAR_ON_RESET=1).
- After clr is sampled, wr_waitrequest is high from the next cycle for DEPTH cycles.
- Throughput: one write plus NUM_READ_PORTS reads every cycle, with no read backpressure.

## Configuration
- LOOKAHEAD_RAM_OUTPUT_REG_EN defined:
  - adds an output register on every read port, giving 2-cycle read latency;
  - adds a second bypass stage per port holding the cycle n+1 write-hit flag and data;
  - resets the extra registers to 0.
- Not defined: 1-cycle latency and a single bypass stage, as described above.

## Structure
- Package lookahead_ram_pkg holds:
  - the clear FSM state typedef (CLEARING, READY);
  - a clog2 function;
  - the packed-port slice helpers.
- Sub-module lookahead_ram_read_port, instantiated NUM_READ_PORTS times. Each instance holds:
  - its own copy of the array, written by the shared write/clear mux, so each maps to a simple dual-port block RAM;
  - its address range check;
  - its bypass stage(s);
  - its optional output register.
- The top level holds the clear FSM, the counter, and the write/clear mux.

## Test plan
- DEPTH=5, CLEAR_ON_RESET=1, release reset: wr_waitrequest falls on the 5th edge; reading addresses 0-4 on each port returns 0.
- Write 0xA5 to address 3 with both ports reading address 3 in the same cycle: both ports return 0xA5 next cycle. With the macro, write 0x11 in cycle n and 0x22 in cycle n+1: both ports return 0x22 at n+2.
- Write 0x3C with wr_waitrequest=1, or write to address 7 with DEPTH=5: memory is unchanged, no bypass occurs, and reads return 0.
- Fill addresses 0-4 with 0xFF, pulse clr for one cycle: wr_waitrequest is high for 5 cycles, then all locations read 0.
- Assert reset_n low two cycles into a clear: outputs go to reset values asynchronously; after release the full DEPTH-cycle clear repeats.
- Random writes and reads against a mirror model for 100×DEPTH cycles, all ports, with and without LOOKAHEAD_RAM_OUTPUT_REG_EN: no mismatches.
